car_motion_ctrl: RTL and testbench



---
 rtl/car_pkg.sv | 16 +
 rtl/car_axis.sv | 81 ++++++++
 rtl/car_motion_ctrl.sv | 103 ++++++++++
 tb/tb_car_motion_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/car_pkg.sv
// rtl/car_pkg.sv - shared FSM state type, default keycodes and velocity-limit helper for car_motion_ctrl
package car_pkg;

  typedef enum logic [1:0] {ARM, RUN, PAUSE} car_state_e;

  localparam logic [7:0] DEF_KEY_LEFT    = 8'h04;
  localparam logic [7:0] DEF_KEY_RIGHT   = 8'h07;
  localparam logic [7:0] DEF_KEY_DOWN    = 8'h16;
  localparam logic [7:0] DEF_KEY_UP      = 8'h1A;
  localparam logic [7:0] DEF_KEY_RESTART = 8'h15;

  function automatic int vel_limit(input int vmax, input logic boost);
    return boost ? 2 * vmax : vmax;
  endfunction

endpackage

// File: rtl/car_axis.sv
// rtl/car_axis.sv - one motion axis: velocity saturation/decay, position add, bound clamp and hit flag
module car_axis
  import car_pkg::*;
#(
  parameter int         POS_W   = 10,
  parameter int         VEL_W   = 5,
  parameter int         MIN     = 47,
  parameter int         MAX     = 233,
  parameter int         START   = 140,
  parameter logic [7:0] KEY_POS = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_NEG = DEF_KEY_LEFT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    restart,
  input  logic                    move,
  input  logic                    tick,
  input  logic [7:0]              keycode,
  input  logic signed [VEL_W-1:0] limit,
  output logic [POS_W-1:0]        pos,
  output logic signed [VEL_W-1:0] vel,
  output logic                    hit
);

  localparam int SW = POS_W + 2;
  localparam logic signed [SW-1:0]    MIN_S = SW'(MIN);
  localparam logic signed [SW-1:0]    MAX_S = SW'(MAX);
  localparam logic signed [VEL_W-1:0] ONE   = VEL_W'(1);

  logic signed [SW-1:0]    sum;
  logic signed [VEL_W-1:0] target;
  logic signed [VEL_W-1:0] vel_next;
  logic                    clamp_lo;
  logic                    clamp_hi;

  // Velocity always walks one step toward the key's target; this also pulls an
  // over-limit velocity back down to the limit once boost is released.
  always_comb begin
    target = '0;
    if (keycode == KEY_POS)
      target = limit;
    else if (keycode == KEY_NEG)
      target = -limit;

    vel_next = vel;
    if (vel < target)
      vel_next = vel + ONE;
    else if (vel > target)
      vel_next = vel - ONE;

    sum      = $signed({2'b00, pos}) + SW'(vel);
    clamp_lo = (sum < MIN_S);
    clamp_hi = (sum > MAX_S);
  end

  // Pushing against a wall the car already touches re-clamps without a new hit.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pos <= POS_W'(START);
      vel <= '0;
      hit <= 1'b0;
    end else if (move) begin
      if (clamp_lo) begin
        pos <= POS_W'(MIN);
        vel <= '0;
        hit <= (pos != POS_W'(MIN));
      end else if (clamp_hi) begin
        pos <= POS_W'(MAX);
        vel <= '0;
        hit <= (pos != POS_W'(MAX));
      end else begin
        pos <= sum[POS_W-1:0];
        vel <= tick ? vel_next : vel;
        hit <= 1'b0;
      end
    end else begin
      hit <= 1'b0;
    end
  end

endmodule

// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - keycode-driven 2-D sprite mover with arm/run/pause FSM and accel counter
// Optional boost input and doubled velocity limit enabled by CAR_BOOST_EN.
module car_motion_ctrl
  import car_pkg::*;
#(
  parameter int         POS_W       = 10,
  parameter int         VEL_W       = 5,
  parameter int         X_MIN       = 47,
  parameter int         X_MAX       = 233,
  parameter int         Y_MIN       = 5,
  parameter int         Y_MAX       = 155,
  parameter int         X_START     = 140,
  parameter int         Y_START     = 155,
  parameter int         VMAX        = 4,
  parameter int         ACCEL_DIV   = 4,
  parameter logic [7:0] KEY_LEFT    = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT   = DEF_KEY_RIGHT,
  parameter logic [7:0] KEY_DOWN    = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_UP      = DEF_KEY_UP,
  parameter logic [7:0] KEY_RESTART = DEF_KEY_RESTART
) (
  input  logic                    frame_clk,
  input  logic                    Reset,
  input  logic [7:0]              keycode,
  input  logic                    freeze,
`ifdef CAR_BOOST_EN
  input  logic                    boost,
`endif
  output logic [POS_W-1:0]        car_x,
  output logic [POS_W-1:0]        car_y,
  output logic signed [VEL_W-1:0] vel_x,
  output logic signed [VEL_W-1:0] vel_y,
  output logic                    wall_hit,
  output logic [1:0]              state
);

  localparam int CNT_W = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_DIV - 1);

  car_state_e              state_q;
  logic [CNT_W-1:0]        cnt;
  logic                    restart;
  logic                    move;
  logic                    tick;
  logic                    boost_on;
  logic signed [VEL_W-1:0] limit;
  logic                    hit_x;
  logic                    hit_y;

`ifdef CAR_BOOST_EN
  assign boost_on = boost;
`else
  assign boost_on = 1'b0;
`endif

  assign limit   = VEL_W'(vel_limit(VMAX, boost_on));
  assign restart = (state_q != ARM) && (keycode == KEY_RESTART);
  assign move    = (state_q == RUN) && !restart && !freeze;
  assign tick    = move && (cnt == CNT_LAST);

  // ARM waits for a released key so a key held through reset is not acted on.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ARM;
      cnt     <= '0;
    end else if (restart) begin
      state_q <= ARM;
      cnt     <= '0;
    end else begin
      case (state_q)
        ARM:     if (keycode == 8'h00) state_q <= RUN;
        RUN: begin
          if (freeze)
            state_q <= PAUSE;
          else
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        PAUSE:   if (!freeze) state_q <= RUN;
        default: state_q <= ARM;
      endcase
    end
  end

  car_axis #(
    .POS_W(POS_W), .VEL_W(VEL_W), .MIN(X_MIN), .MAX(X_MAX), .START(X_START),
    .KEY_POS(KEY_RIGHT), .KEY_NEG(KEY_LEFT)
  ) u_axis_x (
    .clk(frame_clk), .reset(Reset), .restart(restart), .move(move), .tick(tick),
    .keycode(keycode), .limit(limit), .pos(car_x), .vel(vel_x), .hit(hit_x)
  );

  car_axis #(
    .POS_W(POS_W), .VEL_W(VEL_W), .MIN(Y_MIN), .MAX(Y_MAX), .START(Y_START),
    .KEY_POS(KEY_DOWN), .KEY_NEG(KEY_UP)
  ) u_axis_y (
    .clk(frame_clk), .reset(Reset), .restart(restart), .move(move), .tick(tick),
    .keycode(keycode), .limit(limit), .pos(car_y), .vel(vel_y), .hit(hit_y)
  );

  assign wall_hit = hit_x | hit_y;
  assign state    = state_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb/tb_car_motion_ctrl.sv - directed and random frame stimulus against an integer reference model
// Boost stimulus compiled in only when CAR_BOOST_EN is defined.
module tb_car_motion_ctrl;

  logic              frame_clk = 1'b0;
  logic              Reset     = 1'b1;
  logic [7:0]        keycode   = 8'h00;
  logic              freeze    = 1'b0;
  logic              boost     = 1'b0;
  logic [9:0]        car_x;
  logic [9:0]        car_y;
  logic signed [4:0] vel_x;
  logic signed [4:0] vel_y;
  logic              wall_hit;
  logic [1:0]        state;

  int errors = 0;
  int checks = 0;

  // reference model state, plain integers
  int m_st, m_x, m_y, m_vx, m_vy, m_cnt, m_hx, m_hy;

  always #5 frame_clk = ~frame_clk;

  car_motion_ctrl dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .keycode(keycode),
    .freeze(freeze),
`ifdef CAR_BOOST_EN
    .boost(boost),
`endif
    .car_x(car_x),
    .car_y(car_y),
    .vel_x(vel_x),
    .vel_y(vel_y),
    .wall_hit(wall_hit),
    .state(state)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int toward(input int v, input int t);
    if (v < t) return v + 1;
    if (v > t) return v - 1;
    return v;
  endfunction

  // one axis of motion: returns new pos/vel/hit given direction of held key
  task automatic axis_step(input int lo, input int hi, input int dir, input int lim,
                           input bit tk, inout int p, inout int v, output int h);
    int nxt;
    nxt = p + v;
    h = 0;
    if (nxt < lo || nxt > hi) begin
      int b;
      b = (nxt < lo) ? lo : hi;
      h = (p != b);
      p = b;
      v = 0;
    end else begin
      p = nxt;
      if (tk) v = toward(v, dir * lim);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_x = 140; m_y = 155; m_vx = 0; m_vy = 0; m_cnt = 0; m_hx = 0; m_hy = 0;
  endtask

  task automatic model_step(input int key, input bit frz, input bit rst, input bit bst);
    int dx, dy, lim;
    bit tk;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_st != 0 && key == 8'h15) begin
      model_reset();
      return;
    end
    m_hx = 0; m_hy = 0;
    if (m_st == 0) begin
      if (key == 0) m_st = 1;
    end else if (m_st == 2) begin
      if (!frz) m_st = 1;
    end else if (frz) begin
      m_st = 2;
    end else begin
      tk    = (m_cnt == 3);
      m_cnt = (m_cnt + 1) % 4;
      lim   = bst ? 8 : 4;
      dx = (key == 8'h07) ? 1 : (key == 8'h04) ? -1 : 0;
      dy = (key == 8'h16) ? 1 : (key == 8'h1A) ? -1 : 0;
      axis_step(47, 233, dx, lim, tk, m_x, m_vx, m_hx);
      axis_step(5, 155, dy, lim, tk, m_y, m_vy, m_hy);
    end
  endtask

  task automatic frame(input logic [7:0] key, input bit frz, input bit rst, input bit bst);
    keycode = key;
    freeze  = frz;
    Reset   = rst;
`ifdef CAR_BOOST_EN
    boost   = bst;
`else
    boost   = 1'b0;
`endif
    @(posedge frame_clk);
    model_step(int'(key), frz, rst, boost);
    #1;
    check("car_x", int'(car_x), m_x);
    check("car_y", int'(car_y), m_y);
    check("vel_x", int'(vel_x), m_vx);
    check("vel_y", int'(vel_y), m_vy);
    check("wall_hit", int'(wall_hit), (m_hx | m_hy));
    check("state", int'(state), m_st);
  endtask

  initial begin
    model_reset();

    // reset with a key held, which must be ignored until released
    repeat (2) frame(8'h07, 0, 1, 0);
    check("rst_state", int'(state), 0);
    check("rst_car_x", int'(car_x), 140);
    repeat (3) frame(8'h07, 0, 0, 0);
    check("arm_hold_state", int'(state), 0);
    frame(8'h00, 0, 0, 0);
    check("run_state", int'(state), 1);

    // accelerate right to saturation, then into the right wall
    repeat (16) frame(8'h07, 0, 0, 0);
    check("vx_sat", int'(vel_x), 4);
    check("x_after16", int'(car_x), 164);
    repeat (18) frame(8'h07, 0, 0, 0);
    check("x_clamp", int'(car_x), 233);
    check("vx_clamp", int'(vel_x), 0);
    check("hit_pulse", int'(wall_hit), 1);
    frame(8'h07, 0, 0, 0);
    check("hit_gone", int'(wall_hit), 0);
    repeat (10) frame(8'h07, 0, 0, 0);

    // restart mid-motion, then a held direction key is ignored in ARM
    repeat (6) frame(8'h04, 0, 0, 0);
    frame(8'h15, 0, 0, 0);
    check("restart_state", int'(state), 0);
    check("restart_x", int'(car_x), 140);
    check("restart_vx", int'(vel_x), 0);
    repeat (3) frame(8'h04, 0, 0, 0);
    frame(8'h00, 0, 0, 0);

    // pause with vel_x = 3 and resume
    repeat (12) frame(8'h07, 0, 0, 0);
    check("vx_three", int'(vel_x), 3);
    repeat (10) frame(8'h07, 1, 0, 0);
    check("pause_state", int'(state), 2);
    check("pause_vx", int'(vel_x), 3);
    repeat (8) frame(8'h07, 0, 0, 0);

    // reset wins over restart on the same edge
    frame(8'h15, 0, 1, 0);
    check("rst_over_restart", int'(state), 0);
    frame(8'h00, 0, 0, 0);

`ifdef CAR_BOOST_EN
    repeat (60) frame(8'h04, 0, 0, 0);
    repeat (32) frame(8'h07, 0, 0, 1);
    check("boost_sat", int'(vel_x), 8);
    repeat (12) frame(8'h07, 0, 0, 0);
`endif

    // randomised frames
    begin
      logic [7:0] key;
      int hold;
      key  = 8'h00;
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
        int r;
        bit frz, rst, bst;
        if (hold == 0) begin
          r = $urandom_range(0, 99);
          if (r < 20)      key = 8'h00;
          else if (r < 38) key = 8'h04;
          else if (r < 56) key = 8'h07;
          else if (r < 72) key = 8'h16;
          else if (r < 88) key = 8'h1A;
          else if (r < 91) key = 8'h15;
          else             key = 8'($urandom_range(0, 255));
          hold = $urandom_range(1, 24);
        end
        hold--;
        frz = ($urandom_range(0, 99) < 8);
        rst = ($urandom_range(0, 199) == 0);
        bst = ($urandom_range(0, 1) == 1);
        frame(key, frz, rst, bst);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
